// File: rtl/lcd_spi_rx.sv
`default_nettype none
// lcd_spi_rx: decodes LCD 5-wire SPI traffic into dc-tagged bytes behind a show-ahead FIFO.
// Optional PCD8544 X/Y address tracking is enabled by defining LCD_RX_ADDR_DECODE_EN.
module lcd_spi_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sce,
  input  logic               i_sck,
  input  logic               i_mosi,
  input  logic               i_dc,
  input  logic               i_rst_lcd,
  output logic               o_valid,
  output logic [7:0]         o_data,
  output logic               o_dc,
  input  logic               i_ready,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_overflow,
  output logic               o_frame_err,
  input  logic               i_clr_err
`ifdef LCD_RX_ADDR_DECODE_EN
  ,
  output logic [6:0]         o_x,
  output logic [2:0]         o_y
`endif
);

  // Bit order of the synchronizer vectors: {sce, sck, mosi, dc, rst_lcd}
  localparam logic [4:0]       SYNC_INIT = 5'b10001;
  localparam logic [FIFO_AW:0] DEPTH     = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE   = (FIFO_AW+1)'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [4:0] raw, sync1, sync2;
  logic [1:0] hist;
  logic       sce_s, sck_s, mosi_s, dc_s, lcd_run, sck_rise, sce_rise;

  assign raw = {i_sce, i_sck, i_mosi, i_dc, i_rst_lcd};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= SYNC_INIT;
      sync2 <= SYNC_INIT;
      hist  <= 2'b10;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      hist  <= sync2[4:3];
    end
  end

  assign sce_s    = sync2[4];
  assign sck_s    = sync2[3];
  assign mosi_s   = sync2[2];
  assign dc_s     = sync2[1];
  assign lcd_run  = sync2[0];
  assign sck_rise = sck_s & ~hist[0];
  assign sce_rise = sce_s & ~hist[1];

  state_t     state, state_nxt;
  logic [6:0] shreg, shreg_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic       cap, frame_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    cap        = 1'b0;
    frame_set  = 1'b0;
    case (state)
      IDLE: if (!sce_s) state_nxt = SHIFT;
      SHIFT: begin
        if (sce_rise) begin
          frame_set  = (bitcnt != 3'd0);
          bitcnt_nxt = 3'd0;
          state_nxt  = IDLE;
        end else if (sck_rise) begin
          shreg_nxt  = {shreg[5:0], mosi_s};
          bitcnt_nxt = bitcnt + 3'd1;
          cap        = (bitcnt == 3'd7);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // LCD reset freezes the shifter but leaves the FSM and FIFO alone
    if (!lcd_run) begin
      shreg_nxt  = '0;
      bitcnt_nxt = '0;
      cap        = 1'b0;
    end
  end

  logic       push_pend, cap_dc;
  logic [7:0] cap_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_pend <= 1'b0;
      cap_data  <= '0;
      cap_dc    <= 1'b0;
    end else begin
      push_pend <= cap;
      if (cap) begin
        cap_data <= {shreg, mosi_s};
        cap_dc   <= dc_s;
      end
    end
  end

  logic [8:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [FIFO_AW:0]   level;
  logic [7:0]         head_data;
  logic               head_dc, pop, push, overflow, frame_err;

  assign rd_nxt = rd_ptr + FIFO_AW'(1);
  assign pop    = (level != '0) & i_ready;
  assign push   = push_pend & ((level != DEPTH) | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cap_dc, cap_data};
  end

  // Head is registered so it holds the last popped byte while the FIFO is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      head_data <= '0;
      head_dc   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (pop) begin
        if (level > LVL_ONE) {head_dc, head_data} <= mem[rd_nxt];
        else if (push)       {head_dc, head_data} <= {cap_dc, cap_data};
      end else if (level == '0 && push) begin
        {head_dc, head_data} <= {cap_dc, cap_data};
      end
      overflow  <= (push_pend & ~push) | (overflow & ~i_clr_err);
      frame_err <= frame_set | (frame_err & ~i_clr_err);
    end
  end

  assign o_valid     = (level != '0);
  assign o_data      = head_data;
  assign o_dc        = head_dc;
  assign o_level     = level;
  assign o_overflow  = overflow;
  assign o_frame_err = frame_err;

`ifdef LCD_RX_ADDR_DECODE_EN
  logic [6:0] addr_x;
  logic [2:0] addr_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_x <= '0;
      addr_y <= '0;
    end else if (!lcd_run) begin
      addr_x <= '0;
      addr_y <= '0;
    end else if (push_pend) begin
      if (!cap_dc) begin
        if (cap_data[7])
          addr_x <= (cap_data[6:0] > 7'd83) ? 7'd83 : cap_data[6:0];
        else if (cap_data[7:3] == 5'b01000)
          addr_y <= (cap_data[2:0] > 3'd5) ? 3'd5 : cap_data[2:0];
      end else if (addr_x >= 7'd83) begin
        addr_x <= '0;
        addr_y <= (addr_y >= 3'd5) ? 3'd0 : addr_y + 3'd1;
      end else begin
        addr_x <= addr_x + 7'd1;
      end
    end
  end

  assign o_x = addr_x;
  assign o_y = addr_y;
`endif

endmodule
`default_nettype wire
